// File: rtl/bus2_line_master.sv
// bus2 cache-line master: issues one read or write line transaction on A2/C2/D2 and
// reports completion. Optional response watchdog is enabled with `define BUS2_TIMEOUT_EN.
module bus2_line_master #(
  parameter int ADDR2_BUS_SIZE    = 15,
  parameter int DATA_BUS_SIZE     = 16,
  parameter int CTR2_BUS_SIZE     = 2,
  parameter int CACHE_LINE_SIZE   = 16,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                         CLK,
  input  logic                         RESET,
  inout  wire  [ADDR2_BUS_SIZE-1:0]    A2_WIRE,
  inout  wire  [DATA_BUS_SIZE-1:0]     D2_WIRE,
  inout  wire  [CTR2_BUS_SIZE-1:0]     C2_WIRE,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR2_BUS_SIZE-1:0]    req_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0] req_wdata,
  output logic                         resp_valid,
  output logic                         resp_write,
  output logic [CACHE_LINE_SIZE*8-1:0] resp_rdata,
  output logic                         resp_error,
  output logic [2:0]                   state_dbg
);

  localparam int LINE_W = CACHE_LINE_SIZE * 8;
  localparam int BEATS  = LINE_W / DATA_BUS_SIZE;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

  // A geometry that does not match the offset width would mis-address lines,
  // so such an instance simply never accepts a request.
  localparam bit CFG_OK = (CACHE_LINE_SIZE == (1 << CACHE_OFFSET_SIZE)) &&
                          (DATA_BUS_SIZE % 8 == 0) && (BEATS >= 1) &&
                          (CTR2_BUS_SIZE >= 2) && (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_WAIT = 3'd2,
    RD_DATA = 3'd3,
    WR_DATA = 3'd4,
    WR_WAIT = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t                state;
  logic [BEAT_W-1:0]     beat_q;
  logic                  write_q;
  logic [ADDR2_BUS_SIZE-1:0] addr_q;
  logic [LINE_W-1:0]     wdata_q;
  logic [LINE_W-1:0]     rd_buf;
  logic [LINE_W-1:0]     rd_line_next;
  logic                  c2_resp;

`ifdef BUS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
  logic            resp_error_q;
  assign resp_error = resp_error_q;
`else
  assign resp_error = 1'b0;
`endif

  // Request handshake: a request transfers on a CLK edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, and the request
  // fields are sampled only on that edge.
  assign req_ready = (state == IDLE) && CFG_OK;
  assign state_dbg = state;

  // X or Z on C2 compares unknown and therefore never counts as a response.
  assign c2_resp = (C2_WIRE == C2_RESPONSE);

  always_comb begin
    rd_line_next = rd_buf;
    rd_line_next[int'(beat_q)*DATA_BUS_SIZE +: DATA_BUS_SIZE] = D2_WIRE;
  end

  // The bus is owned only while issuing a read command or streaming write beats.
  assign A2_WIRE = (state == RD_CMD || state == WR_DATA) ? addr_q : {ADDR2_BUS_SIZE{1'bz}};
  assign C2_WIRE = (state == RD_CMD)  ? C2_READ_LINE :
                   (state == WR_DATA) ? ((beat_q == '0) ? C2_WRITE_LINE : C2_NOP) :
                   {CTR2_BUS_SIZE{1'bz}};
  assign D2_WIRE = (state == WR_DATA) ? wdata_q[int'(beat_q)*DATA_BUS_SIZE +: DATA_BUS_SIZE]
                                      : {DATA_BUS_SIZE{1'bz}};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      beat_q     <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_buf     <= '0;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_rdata <= '0;
`ifdef BUS2_TIMEOUT_EN
      to_cnt       <= '0;
      resp_error_q <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
`ifdef BUS2_TIMEOUT_EN
      to_cnt <= '0;
`endif
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            beat_q  <= '0;
            state   <= req_write ? WR_DATA : RD_CMD;
          end
        end
        RD_CMD: state <= RD_WAIT;
        RD_WAIT, RD_DATA: begin
          // Once the burst has started, D2 is captured every cycle without looking at C2.
          if (state == RD_DATA || c2_resp) begin
            rd_buf <= rd_line_next;
            if (beat_q == LAST_BEAT) begin
              beat_q     <= '0;
              resp_rdata <= rd_line_next;
              resp_valid <= 1'b1;
              resp_write <= 1'b0;
`ifdef BUS2_TIMEOUT_EN
              resp_error_q <= 1'b0;
`endif
              state <= DONE;
            end else begin
              beat_q <= beat_q + 1'b1;
              state  <= RD_DATA;
            end
          end
`ifdef BUS2_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            resp_valid   <= 1'b1;
            resp_write   <= write_q;
            resp_error_q <= 1'b1;
            state        <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        WR_DATA: begin
          if (beat_q == LAST_BEAT) begin
            beat_q <= '0;
            state  <= WR_WAIT;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        WR_WAIT: begin
          if (c2_resp) begin
            resp_valid <= 1'b1;
            resp_write <= 1'b1;
`ifdef BUS2_TIMEOUT_EN
            resp_error_q <= 1'b0;
`endif
            state <= DONE;
          end
`ifdef BUS2_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            resp_valid   <= 1'b1;
            resp_write   <= write_q;
            resp_error_q <= 1'b1;
            state        <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus2_line_master.sv
// Directed + randomized bench for bus2_line_master with a bus2 slave model and a
// line-level reference model; released bus wires are pulled up so they read all-ones.
module tb_bus2_line_master;

  localparam int AW     = 15;
  localparam int DW     = 16;
  localparam int CW     = 2;
  localparam int LB     = 16;
  localparam int LW     = LB * 8;
  localparam int BEATS  = LB / 2;
  localparam int TO_CYC = 20;

  localparam logic [CW-1:0] C2_NOP        = 2'd0;
  localparam logic [CW-1:0] C2_RESPONSE   = 2'd1;
  localparam logic [CW-1:0] C2_READ_LINE  = 2'd2;
  localparam logic [CW-1:0] C2_WRITE_LINE = 2'd3;
  localparam logic [AW-1:0] A2_REL = {AW{1'b1}};
  localparam logic [DW-1:0] D2_REL = {DW{1'b1}};
  localparam logic [CW-1:0] C2_REL = {CW{1'b1}};

  // clock / reset
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_write;
  logic [LW-1:0] resp_rdata;
  logic          resp_error;
  logic [2:0]    state_dbg;

  wire [AW-1:0] a2_bus;
  wire [DW-1:0] d2_bus;
  wire [CW-1:0] c2_bus;

  logic          slv_c2_en = 1'b0;
  logic [CW-1:0] slv_c2 = '0;
  logic          slv_d2_en = 1'b0;
  logic [DW-1:0] slv_d2 = '0;
  assign c2_bus = slv_c2_en ? slv_c2 : {CW{1'bz}};
  assign d2_bus = slv_d2_en ? slv_d2 : {DW{1'bz}};

  for (genvar i = 0; i < AW; i++) begin : g_pu_a
    pullup (a2_bus[i]);
  end
  for (genvar i = 0; i < DW; i++) begin : g_pu_d
    pullup (d2_bus[i]);
  end
  for (genvar i = 0; i < CW; i++) begin : g_pu_c
    pullup (c2_bus[i]);
  end

  bus2_line_master #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .A2_WIRE    (a2_bus),
    .D2_WIRE    (d2_bus),
    .C2_WIRE    (c2_bus),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_write (resp_write),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .state_dbg  (state_dbg)
  );

  // scoreboard
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] model_rdata = '0;
  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [LW-1:0] pack_line(input logic [7:0] b[LB]);
    logic [LW-1:0] line;
    line = '0;
    for (int k = 0; k < LB; k++) line = line | (LW'(b[k]) << (8 * k));
    return line;
  endfunction

  task automatic chk_released(input string tag);
    chk({tag, "_a2"}, LW'(a2_bus), LW'(A2_REL));
    chk({tag, "_c2"}, LW'(c2_bus), LW'(C2_REL));
    chk({tag, "_d2"}, LW'(d2_bus), LW'(D2_REL));
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] b[LB], input int delay,
                         input bit hold, input logic [AW-1:0] nxt_addr,
                         input logic [LW-1:0] nxt_wdata);
    logic [LW-1:0] line;
    line = pack_line(b);
    exp_q.push_back(line);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    tick();
    chk("rd_cmd_c2", LW'(c2_bus), LW'(C2_READ_LINE));
    chk("rd_cmd_a2", LW'(a2_bus), LW'(addr));
    chk("rd_cmd_d2", LW'(d2_bus), LW'(D2_REL));
    chk("rd_cmd_ready", LW'(req_ready), LW'(0));
    if (hold) begin
      req_write = 1'b1;
      req_addr  = nxt_addr;
      req_wdata = nxt_wdata;
    end else begin
      req_valid = 1'b0;
      req_addr  = AW'($urandom);
    end
    tick();
    chk_released("rd_wait");
    for (int k = 0; k < delay; k++) begin
      chk("rd_wait_valid", LW'(resp_valid), LW'(0));
      chk("rd_wait_ready", LW'(req_ready), LW'(0));
      tick();
    end
    for (int i = 0; i < BEATS; i++) begin
      slv_d2_en = 1'b1;
      slv_d2    = {b[2*i+1], b[2*i]};
      slv_c2_en = (i == 0);
      slv_c2    = C2_RESPONSE;
      if (i > 0) chk("rd_burst_valid", LW'(resp_valid), LW'(0));
      tick();
    end
    slv_d2_en = 1'b0;
    slv_c2_en = 1'b0;
    chk("rd_done_valid", LW'(resp_valid), LW'(1));
    chk("rd_done_write", LW'(resp_write), LW'(0));
    chk("rd_done_error", LW'(resp_error), LW'(0));
    chk("rd_line", resp_rdata, exp_q.pop_front());
    model_rdata = line;
    tick();
    chk("rd_idle_valid", LW'(resp_valid), LW'(0));
    chk("rd_idle_ready", LW'(req_ready), LW'(1));
    chk("rd_hold_line", resp_rdata, model_rdata);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] b[LB], input int delay,
                          input int spur);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    req_wdata = pack_line(b);
    tick();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < BEATS; i++) begin
      if (!(spur >= 0 && i == spur + 1))
        chk("wr_c2", LW'(c2_bus), LW'((i == 0) ? C2_WRITE_LINE : C2_NOP));
      chk("wr_a2", LW'(a2_bus), LW'(addr));
      chk("wr_d2", LW'(d2_bus), LW'({b[2*i+1], b[2*i]}));
      chk("wr_ready", LW'(req_ready), LW'(0));
      // a stray RESPONSE during the write stream must be ignored
      slv_c2_en = (i == spur);
      slv_c2    = C2_RESPONSE;
      tick();
    end
    chk_released("wr_wait");
    for (int k = 0; k < delay; k++) begin
      chk("wr_wait_valid", LW'(resp_valid), LW'(0));
      tick();
    end
    slv_c2_en = 1'b1;
    slv_c2    = C2_RESPONSE;
    tick();
    slv_c2_en = 1'b0;
    chk("wr_done_valid", LW'(resp_valid), LW'(1));
    chk("wr_done_write", LW'(resp_write), LW'(1));
    chk("wr_done_error", LW'(resp_error), LW'(0));
    chk("wr_keeps_rdata", resp_rdata, model_rdata);
    tick();
    chk("wr_idle_valid", LW'(resp_valid), LW'(0));
    chk("wr_idle_ready", LW'(req_ready), LW'(1));
  endtask

  initial begin
    logic [7:0] b[LB];
    logic [7:0] b2[LB];
    logic [AW-1:0] a_nxt;

    // reset state
    repeat (3) tick();
    chk_released("rst");
    chk("rst_valid", LW'(resp_valid), LW'(0));
    chk("rst_write", LW'(resp_write), LW'(0));
    chk("rst_error", LW'(resp_error), LW'(0));
    chk("rst_rdata", resp_rdata, LW'(0));
    RESET = 1'b1;
    #1;
    chk("rst_ready", LW'(req_ready), LW'(1));
    tick();

    // stray RESPONSE while idle
    slv_c2_en = 1'b1;
    slv_c2    = C2_RESPONSE;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_spur_valid", LW'(resp_valid), LW'(0));
      chk("idle_spur_ready", LW'(req_ready), LW'(1));
    end
    slv_c2_en = 1'b0;
    tick();

    // directed read: line 0x0012, bytes 0x10..0x1F, six-cycle slave delay
    for (int k = 0; k < LB; k++) b[k] = 8'(8'h10 + k);
    do_read(15'h0012, b, 6, 1'b0, '0, '0);
    chk("rd_directed_value", resp_rdata, 128'h1F1E1D1C1B1A19181716151413121110);

    // directed write: line 0x0003, bytes 0xA0..0xAF, stray RESPONSE at beat 4
    for (int k = 0; k < LB; k++) b[k] = 8'(8'hA0 + k);
    do_write(15'h0003, b, 2, 4);

    // read with req_valid held: the queued write is taken only after DONE
    for (int k = 0; k < LB; k++) b[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < LB; k++) b2[k] = 8'($urandom_range(0, 255));
    a_nxt = AW'($urandom_range(0, 32767));
    do_read(AW'($urandom_range(0, 32767)), b, 3, 1'b1, a_nxt, pack_line(b2));
    do_write(a_nxt, b2, 1, -1);

    // randomized transactions
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < LB; k++) b[k] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom_range(0, 32767)), b, $urandom_range(0, 5), $urandom_range(0, 1) == 1 ? int'($urandom_range(0, BEATS - 2)) : -1);
      else
        do_read(AW'($urandom_range(0, 32767)), b, $urandom_range(0, 5), 1'b0, '0, '0);
    end

    // reset in RD_WAIT aborts without a completion
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 15'h0055;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    #1;
    chk_released("rst_rdwait");
    chk("rst_rdwait_valid", LW'(resp_valid), LW'(0));
    model_rdata = '0;
    tick();
    chk("rst_rdwait_rdata", resp_rdata, model_rdata);
    RESET = 1'b1;
    #1;
    chk("rst_rdwait_ready", LW'(req_ready), LW'(1));
    tick();

    // reset while streaming a write releases the bus immediately
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 15'h1234;
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_rst_wr_a2", LW'(a2_bus), LW'(15'h1234));
    RESET = 1'b0;
    #1;
    chk_released("rst_wrdata");
    chk("rst_wrdata_valid", LW'(resp_valid), LW'(0));
    tick();
    chk("rst_wrdata_valid2", LW'(resp_valid), LW'(0));
    RESET = 1'b1;
    #1;
    chk("rst_wrdata_ready", LW'(req_ready), LW'(1));
    tick();

    // a full read after the aborted transactions
    for (int k = 0; k < LB; k++) b[k] = 8'($urandom_range(0, 255));
    do_read(15'h7001, b, 0, 1'b0, '0, '0);

`ifdef BUS2_TIMEOUT_EN
    // no slave: completion with error after TO_CYC wait cycles
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 15'h0100;
    tick();
    req_valid = 1'b0;
    tick();
    for (int k = 0; k < TO_CYC; k++) begin
      chk("to_wait_valid", LW'(resp_valid), LW'(0));
      tick();
    end
    chk("to_valid", LW'(resp_valid), LW'(1));
    chk("to_error", LW'(resp_error), LW'(1));
    chk("to_write", LW'(resp_write), LW'(0));
    chk("to_rdata", resp_rdata, model_rdata);
    tick();
`endif

    chk("scoreboard_empty", LW'(exp_q.size()), LW'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
